// File: rtl/amba3_apb_slave_mem.sv
// APB3 completer backed by a flop word memory with programmable wait states.
// Define AMBA3_APB_SLAVE_RANDOM_WAIT_EN for LFSR-driven per-transfer wait counts.
module amba3_apb_slave_mem #(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic                 pready,
    output logic [DATA_SIZE-1:0] prdata
);

    localparam int unsigned IdxW    = $clog2(DEPTH);
    localparam int unsigned AddrLsb = $clog2(DATA_SIZE / 8);
    localparam logic [3:0]  WaitMax = 4'(WAIT_CYCLES);

    if (!(DATA_SIZE == 8 || DATA_SIZE == 16 || DATA_SIZE == 32 || DATA_SIZE == 64)) begin : g_bad_data
        $error("DATA_SIZE must be 8, 16, 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be 0..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic [IdxW-1:0]        idx_q;
    logic                   in_range_q;
    logic                   write_q;
    logic                   pready_q;
    logic [DATA_SIZE-1:0]   prdata_q;
    logic [DATA_SIZE-1:0]   mem_q [DEPTH];

    logic [IdxW-1:0]        idx_in;
    logic                   in_range_in;
    logic [DATA_SIZE-1:0]   rd_word_in;
    logic [DATA_SIZE-1:0]   rd_word_q;
    logic [3:0]             wait_w;
    logic                   unused_paddr;

    assign idx_in       = paddr[AddrLsb +: IdxW];
    assign unused_paddr = ^paddr;

    // Power-of-two depth: the access is in range iff no address bit above the index is set.
    if (ADDR_SIZE > AddrLsb + IdxW) begin : g_range_chk
        assign in_range_in = ~|paddr[ADDR_SIZE-1:AddrLsb+IdxW];
    end else begin : g_range_all
        assign in_range_in = 1'b1;
    end

    assign rd_word_in = in_range_in ? mem_q[idx_in] : '0;
    assign rd_word_q  = in_range_q  ? mem_q[idx_q]  : '0;

`ifdef AMBA3_APB_SLAVE_RANDOM_WAIT_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign wait_w  = (lfsr_q[3:0] < WaitMax) ? lfsr_q[3:0] : WaitMax;
`else
    assign wait_w  = WaitMax;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            write_q    <= 1'b0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
`ifdef AMBA3_APB_SLAVE_RANDOM_WAIT_EN
            lfsr_q     <= 8'hA5;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    // penable without psel setup is a protocol violation and is ignored here.
                    if (psel && !penable) begin
                        idx_q      <= idx_in;
                        in_range_q <= in_range_in;
                        write_q    <= pwrite;
`ifdef AMBA3_APB_SLAVE_RANDOM_WAIT_EN
                        lfsr_q     <= {lfsr_q[6:0], lfsr_fb};
`endif
                        if (wait_w == 4'd0) begin
                            state_q  <= StReady;
                            pready_q <= 1'b1;
                            if (!pwrite) begin
                                prdata_q <= rd_word_in;
                            end
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= wait_w;
                        end
                    end
                end
                StWait: begin
                    if (!psel) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (penable) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q  <= StReady;
                            pready_q <= 1'b1;
                            if (!write_q) begin
                                prdata_q <= rd_word_q;
                            end
                        end
                    end
                end
                StReady: begin
                    if (!psel) begin
                        state_q  <= StIdle;
                        pready_q <= 1'b0;
                    end else if (penable) begin
                        if (write_q && in_range_q) begin
                            mem_q[idx_q] <= pwdata;
                        end
                        state_q  <= StIdle;
                        pready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pready = pready_q;
    assign prdata = prdata_q;

endmodule

// File: tb/tb_amba3_apb_slave_mem.sv
// Scoreboard bench: the master task queues expected results, a negedge monitor checks them.
module tb_amba3_apb_slave_mem;

    logic        pclk;
    logic        preset_n;
    logic [31:0] paddr;
    logic [3:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pready_v;
    logic [31:0] prdata_v [4];

    int checks;
    int errors;
    int cur;
    int wait_cnt;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t exp_q [$];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    amba3_apb_slave_mem #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0])
    );
    amba3_apb_slave_mem #(.WAIT_CYCLES(3)) dut3 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1])
    );
    amba3_apb_slave_mem #(.WAIT_CYCLES(2)) dut2 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[2]), .prdata(prdata_v[2])
    );
`ifdef AMBA3_APB_SLAVE_RANDOM_WAIT_EN
    amba3_apb_slave_mem #(.WAIT_CYCLES(15)) dut15 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel_v[3]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[3]), .prdata(prdata_v[3])
    );
`else
    assign pready_v[3] = 1'b0;
    assign prdata_v[3] = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: counts stalled access cycles and scores each completed transfer.
    always @(negedge pclk) begin
        if (preset_n && psel_v[cur]) begin
            if (!penable) begin
                wait_cnt = 0;
            end else if (!pready_v[cur]) begin
                wait_cnt++;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pready: dut %0d completed with empty queue", cur);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wait_states", 32'(wait_cnt), 32'(e.waits));
                if (e.rd) check("read_data", prdata_v[cur], e.data);
                wait_cnt = 0;
            end
        end
    end

    // Caller enters just after a rising edge; returns just after the completing edge.
    task automatic xfer(input int d, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int ew);
        bit done;
        exp_q.push_back('{rd: !wr, data: exp_rd, waits: ew});
        cur     = d;
        paddr   = a;
        pwrite  = wr;
        pwdata  = wd;
        psel_v  = 4'b0001 << d;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (pready_v[d]) done = 1'b1;
            @(posedge pclk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout: dut %0d addr %h no pready within 40 cycles", d, a);
        end
        psel_v  = '0;
        penable = 1'b0;
    endtask

    task automatic do_reset();
        #1 preset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_pready", 32'(pready_v[i]), 32'd0);
            check("reset_prdata", prdata_v[i], 32'd0);
        end
        @(posedge pclk);
        #2 preset_n = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cur      = 0;
        wait_cnt = 0;
        preset_n = 1'b1;
        paddr    = '0;
        psel_v   = '0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        pwdata   = '0;
        @(posedge pclk);
        do_reset();

        // Zero wait states: basic read/write, low address bits, range boundary.
        xfer(0, 32'h10,  1'b0, 32'h0,         32'h0,         0);
        xfer(0, 32'h40,  1'b1, 32'hDEAD_BEEF, 32'h0,         0);
        xfer(0, 32'h40,  1'b0, 32'h0,         32'hDEAD_BEEF, 0);
        xfer(0, 32'h44,  1'b0, 32'h0,         32'h0,         0);
        xfer(0, 32'h42,  1'b0, 32'h0,         32'hDEAD_BEEF, 0);
        xfer(0, 32'h0,   1'b1, 32'h1111_2222, 32'h0,         0);
        check("prdata_hold_on_write", prdata_v[0], 32'hDEAD_BEEF);
        xfer(0, 32'h400, 1'b1, 32'hFFFF_FFFF, 32'h0,         0);
        xfer(0, 32'h400, 1'b0, 32'h0,         32'h0,         0);
        xfer(0, 32'h0,   1'b0, 32'h0,         32'h1111_2222, 0);
        xfer(0, 32'h3FC, 1'b1, 32'hCAFE_F00D, 32'h0,         0);
        xfer(0, 32'h3FC, 1'b0, 32'h0,         32'hCAFE_F00D, 0);

        // Three wait states.
        xfer(1, 32'h8, 1'b1, 32'h1234_5678, 32'h0,         3);
        xfer(1, 32'h8, 1'b0, 32'h0,         32'h1234_5678, 3);

        // Abort a write on psel drop after one wait cycle.
        cur     = 2;
        paddr   = 32'h20;
        pwrite  = 1'b1;
        pwdata  = 32'hA5A5_A5A5;
        psel_v  = 4'b0100;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1 psel_v  = '0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        xfer(2, 32'h20, 1'b0, 32'h0,         32'h0,         2);
        xfer(2, 32'h4,  1'b1, 32'h55AA_55AA, 32'h0,         2);
        xfer(2, 32'h4,  1'b0, 32'h0,         32'h55AA_55AA, 2);

        // Reset asserted in a wait cycle of a read.
        cur     = 2;
        paddr   = 32'h4;
        pwrite  = 1'b0;
        psel_v  = 4'b0100;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        check("prdata_before_reset", prdata_v[2], 32'h55AA_55AA);
        psel_v  = '0;
        penable = 1'b0;
        do_reset();
        xfer(2, 32'h4,  1'b0, 32'h0, 32'h0, 2);
        xfer(0, 32'h40, 1'b0, 32'h0, 32'h0, 0);

`ifdef AMBA3_APB_SLAVE_RANDOM_WAIT_EN
        begin
            logic [7:0] lfsr;
            lfsr = 8'hA5;
            for (int i = 0; i < 8; i++) begin
                xfer(3, 32'(i * 4), 1'b1, 32'hC0DE_0000 + 32'(i), 32'h0, int'(lfsr[3:0]));
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            for (int i = 0; i < 8; i++) begin
                xfer(3, 32'(i * 4), 1'b0, 32'h0, 32'hC0DE_0000 + 32'(i), int'(lfsr[3:0]));
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
        end
`endif

        repeat (3) @(posedge pclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
